// File: rtl/adpll_pkg.sv
// Shared types and widths for the ADPLL PFD/TDC measurement path.
package adpll_pkg;

    localparam int unsigned TDC_CNT_W    = 5;
    localparam int unsigned PHASE_ERR_W  = 7;
    localparam int unsigned LOCK_TOL_DEF = 2;
    localparam int unsigned LOCK_CNT_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WAIT_DONE,
        ST_CAPTURE,
        ST_REARM,
        ST_FAULT
    } meas_state_t;

    function automatic logic [PHASE_ERR_W-1:0] abs_err(input logic [PHASE_ERR_W-1:0] v);
        return v[PHASE_ERR_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/sync_pulse_det.sv
// Multi-flop synchronizer for an asynchronous strobe followed by a rising-edge detector.
module sync_pulse_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pfd_tdc_meas_ctrl.sv
// PFD/backup-TDC measurement sequencer: arms the TDC, waits for done with timeout,
// forms a signed phase-error word and tracks lock over consecutive measurements.
module pfd_tdc_meas_ctrl
    import adpll_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned TIMEOUT_CYC = 15,
    parameter int unsigned LOCK_TOL    = LOCK_TOL_DEF,
    parameter int unsigned LOCK_CNT    = LOCK_CNT_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   ref_clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   use_external,
    input  logic                   fine_done_pre,
    input  logic                   early,
    input  logic [TDC_CNT_W-1:0]   counter_rise,
    input  logic [TDC_CNT_W-1:0]   counter_fall,
    output logic                   enable_PFD_TDC,
    output logic                   select_PFD_input,
    output logic [PHASE_ERR_W-1:0] phase_err,
    output logic                   err_valid,
    output logic                   lock,
    output logic                   timeout_err,
    output logic                   busy
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned LCK_W = $clog2(LOCK_CNT + 1);

    meas_state_t            state_q, state_d;
    logic [SET_W-1:0]       settle_cnt;
    logic [TMO_W-1:0]       tmo_cnt;
    logic [LCK_W-1:0]       lock_cnt;
    logic [LCK_W-1:0]       lock_cnt_inc;
    logic [PHASE_ERR_W-1:0] mag;
    logic                   done_re;
    logic                   in_tol;

    sync_pulse_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_done_sync (
        .clk  (ref_clk),
        .rst  (reset),
        .din  (fine_done_pre),
        .pulse(done_re)
    );

    assign mag          = PHASE_ERR_W'(counter_rise) + PHASE_ERR_W'(counter_fall);
    assign in_tol       = abs_err(phase_err) <= PHASE_ERR_W'(LOCK_TOL);
    assign lock_cnt_inc = (lock_cnt == LCK_W'(LOCK_CNT)) ? lock_cnt : lock_cnt + LCK_W'(1);

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        enable_PFD_TDC = 1'b0;
        err_valid      = 1'b0;
        busy           = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                enable_PFD_TDC = 1'b1;
                if (!run)                                    state_d = ST_IDLE;
                else if (settle_cnt == SET_W'(SETTLE_CYC - 1)) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                enable_PFD_TDC = 1'b1;
                // done_re outranks the timeout; dropping run abandons the measurement outright
                if (!run)                                     state_d = ST_IDLE;
                else if (done_re)                             state_d = ST_CAPTURE;
                else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1))  state_d = ST_FAULT;
            end
            ST_CAPTURE: state_d = ST_REARM;
            ST_REARM: begin
                err_valid = 1'b1;
                state_d   = run ? ST_SETTLE : ST_IDLE;
            end
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
            tmo_cnt    <= '0;
        end else begin
            settle_cnt <= (state_q == ST_SETTLE)    ? settle_cnt + SET_W'(1) : '0;
            tmo_cnt    <= (state_q == ST_WAIT_DONE) ? tmo_cnt + TMO_W'(1)    : '0;
        end
    end

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            select_PFD_input <= 1'b0;
            phase_err        <= '0;
            lock_cnt         <= '0;
            lock             <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    select_PFD_input <= use_external;
                    if (use_external != select_PFD_input) begin
                        lock_cnt <= '0;
                        lock     <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    phase_err <= early ? -mag : mag;
                end
                ST_REARM: begin
                    timeout_err <= 1'b0;
                    if (in_tol) begin
                        lock_cnt <= lock_cnt_inc;
                        lock     <= (lock_cnt_inc == LCK_W'(LOCK_CNT));
                    end else begin
                        lock_cnt <= '0;
                        lock     <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    timeout_err <= 1'b1;
                    lock_cnt    <= '0;
                    lock        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pfd_tdc_meas_ctrl.sv
// Self-checking bench for pfd_tdc_meas_ctrl: directed vector table, corner sequences, random measurements.
module tb_pfd_tdc_meas_ctrl;
    import adpll_pkg::*;

    logic       ref_clk = 1'b0;
    logic       reset, run, use_external, fine_done_pre, early;
    logic [4:0] counter_rise, counter_fall;
    logic       enable_PFD_TDC, select_PFD_input, err_valid, lock, timeout_err, busy;
    logic [6:0] phase_err;

    int total = 0;
    int bad   = 0;
    int m_cnt = 0;
    bit m_terr = 1'b0;

    typedef struct {
        bit e;
        int r;
        int f;
        int pe;
        bit lk;
    } vec_t;
    vec_t tbl[14];

    always #5 ref_clk = ~ref_clk;

    pfd_tdc_meas_ctrl dut (
        .ref_clk         (ref_clk),
        .reset           (reset),
        .run             (run),
        .use_external    (use_external),
        .fine_done_pre   (fine_done_pre),
        .early           (early),
        .counter_rise    (counter_rise),
        .counter_fall    (counter_fall),
        .enable_PFD_TDC  (enable_PFD_TDC),
        .select_PFD_input(select_PFD_input),
        .phase_err       (phase_err),
        .err_valid       (err_valid),
        .lock            (lock),
        .timeout_err     (timeout_err),
        .busy            (busy)
    );

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ref_clk);
        #1;
    endtask

    // Reference rules: signed error from counts, then the lock-run bookkeeping.
    function automatic int model_pe(input bit e, input int r, input int f);
        return e ? -(r + f) : (r + f);
    endfunction

    task automatic model_good(input int pe);
        if (pe <= int'(LOCK_TOL_DEF) && pe >= -int'(LOCK_TOL_DEF))
            m_cnt = (m_cnt < int'(LOCK_CNT_DEF)) ? m_cnt + 1 : m_cnt;
        else
            m_cnt = 0;
        m_terr = 1'b0;
    endtask

    function automatic int m_lock();
        return (m_cnt == int'(LOCK_CNT_DEF)) ? 1 : 0;
    endfunction

    task automatic do_meas(input bit e, input int r, input int f, input int dly, input bit stop,
                           input int exp_pe, input int exp_lk, input string tag);
        int n;
        early        = e;
        counter_rise = 5'(r);
        counter_fall = 5'(f);
        n = 0;
        while (!enable_PFD_TDC && n < 40) begin step(); n++; end
        chk({tag, "_arm"}, int'(enable_PFD_TDC), 1);
        repeat (dly) step();
        fine_done_pre = 1'b1;
        n = 0;
        while (!err_valid && n < 40) begin step(); n++; end
        chk({tag, "_valid"}, int'(err_valid), 1);
        chk({tag, "_pe"}, int'($signed(phase_err)), exp_pe);
        fine_done_pre = 1'b0;
        if (stop) run = 1'b0;
        step();
        chk({tag, "_pulse"}, int'(err_valid), 0);
        chk({tag, "_lock"}, int'(lock), exp_lk);
        chk({tag, "_terr"}, int'(timeout_err), int'(m_terr));
    endtask

    task automatic rand_meas(input bit stop, input string tag);
        bit e;
        int r, f, pe;
        e = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) != 0) begin
            r = int'($urandom_range(0, 2));
            f = int'($urandom_range(0, 1));
        end else begin
            r = int'($urandom_range(0, 31));
            f = int'($urandom_range(0, 31));
        end
        pe = model_pe(e, r, f);
        model_good(pe);
        do_meas(e, r, f, int'($urandom_range(1, 8)), stop, pe, m_lock(), tag);
    endtask

    task automatic do_timeout(input string tag);
        int n;
        int en_cyc;
        fine_done_pre = 1'b0;
        n = 0;
        while (!enable_PFD_TDC && n < 40) begin step(); n++; end
        chk({tag, "_arm"}, int'(enable_PFD_TDC), 1);
        en_cyc = 0;
        while (enable_PFD_TDC && en_cyc < 40) begin step(); en_cyc++; end
        chk({tag, "_en_cycles"}, en_cyc, 17);
        chk({tag, "_en_low"}, int'(enable_PFD_TDC), 0);
        step();
        m_cnt  = 0;
        m_terr = 1'b1;
        chk({tag, "_flag"}, int'(timeout_err), 1);
        chk({tag, "_lock"}, int'(lock), 0);
    endtask

    initial begin
        int n;
        int ev;
        int pe_seen;

        reset         = 1'b1;
        run           = 1'b0;
        use_external  = 1'b0;
        fine_done_pre = 1'b0;
        early         = 1'b0;
        counter_rise  = '0;
        counter_fall  = '0;

        tbl[0] = '{1'b1, 3, 2, -5, 1'b0};
        for (int i = 1; i <= 8; i++) tbl[i] = '{1'b0, 1, 0, 1, (i == 8)};
        tbl[9]  = '{1'b0, 4, 0, 4, 1'b0};
        tbl[10] = '{1'b1, 1, 1, -2, 1'b0};
        tbl[11] = '{1'b1, 2, 1, -3, 1'b0};
        tbl[12] = '{1'b0, 31, 31, 62, 1'b0};
        tbl[13] = '{1'b1, 31, 31, -62, 1'b0};

        step();
        step();
        chk("rst_enable", int'(enable_PFD_TDC), 0);
        chk("rst_select", int'(select_PFD_input), 0);
        chk("rst_phase_err", int'(phase_err), 0);
        chk("rst_err_valid", int'(err_valid), 0);
        chk("rst_lock", int'(lock), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        step();

        // Directed vector table, back-to-back measurements.
        run = 1'b1;
        for (int i = 0; i < 14; i++) begin
            model_good(model_pe(tbl[i].e, tbl[i].r, tbl[i].f));
            do_meas(tbl[i].e, tbl[i].r, tbl[i].f, 1 + (i % 4), (i == 13),
                    tbl[i].pe, int'(tbl[i].lk), $sformatf("vec%0d", i));
        end
        n = 0;
        while (busy && n < 20) begin step(); n++; end
        chk("vec_idle", int'(busy), 0);

        // Timeout, then a good measurement clears the sticky flag.
        run = 1'b1;
        do_timeout("tmo");
        chk("tmo_sticky", int'(timeout_err), 1);
        model_good(2);
        do_meas(1'b0, 0, 2, 2, 1'b1, 2, m_lock(), "tmo_recover");
        n = 0;
        while (busy && n < 20) begin step(); n++; end

        // Stale done: level already high on entry to WAIT_DONE.
        fine_done_pre = 1'b1;
        early         = 1'b0;
        counter_rise  = 5'd2;
        counter_fall  = 5'd0;
        repeat (4) step();
        run = 1'b1;
        n = 0;
        while (!enable_PFD_TDC && n < 10) begin step(); n++; end
        ev = 0;
        repeat (6) begin step(); ev += int'(err_valid); end
        chk("stale_none", ev, 0);
        fine_done_pre = 1'b0;
        repeat (3) step();
        fine_done_pre = 1'b1;
        ev      = 0;
        pe_seen = 999;
        repeat (10) begin
            step();
            if (err_valid) pe_seen = int'($signed(phase_err));
            ev += int'(err_valid);
        end
        chk("stale_one", ev, 1);
        chk("stale_pe", pe_seen, 2);
        model_good(2);
        run = 1'b0;
        fine_done_pre = 1'b0;
        n = 0;
        while (busy && n < 10) begin step(); n++; end
        chk("abandon_idle", int'(busy), 0);
        chk("abandon_enable", int'(enable_PFD_TDC), 0);
        chk("abandon_lock", int'(lock), m_lock());

        // Select change while locked.
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            model_good(0);
            do_meas(1'b0, 0, 0, 2, 1'b0, 0, m_lock(), $sformatf("sel_acq%0d", i));
        end
        use_external = 1'b1;
        model_good(0);
        do_meas(1'b0, 0, 0, 3, 1'b1, 0, m_lock(), "sel_last");
        chk("sel_hold", int'(select_PFD_input), 0);
        step();
        m_cnt = 0;
        chk("sel_new", int'(select_PFD_input), 1);
        chk("sel_lock_clr", int'(lock), 0);

        // Reset in WAIT_DONE while locked.
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            model_good(-1);
            do_meas(1'b1, 1, 0, 1, 1'b0, -1, m_lock(), $sformatf("rst_acq%0d", i));
        end
        repeat (3) step();
        chk("pre_rst_enable", int'(enable_PFD_TDC), 1);
        chk("pre_rst_lock", int'(lock), 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_enable", int'(enable_PFD_TDC), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_lock", int'(lock), 0);
        chk("midrst_timeout_err", int'(timeout_err), 0);
        #2 reset = 1'b0;
        m_cnt  = 0;
        m_terr = 1'b0;
        step();
        chk("post_rst_enable", int'(enable_PFD_TDC), 1);
        chk("post_rst_busy", int'(busy), 1);

        // Random measurements with occasional timeouts, continuous run.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) do_timeout($sformatf("rnd_tmo%0d", i));
            else rand_meas(1'b0, $sformatf("rnd%0d", i));
        end
        rand_meas(1'b1, "rnd_last");
        n = 0;
        while (busy && n < 20) begin step(); n++; end
        chk("final_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
